// File: rtl/pc_trace_buffer_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared constants for the PC trace capture block: FSM state encodings,
// the location of the PC (R7) inside the procMulticiclo register bus, and
// the width of one trace entry.
//
// Build option: TRACE_TIMESTAMP_EN widens each entry from {PC, DIN} (32 bits)
// to {PC, DIN, stamp} (48 bits).
// ---------------------------------------------------------------------------
package trace_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_POST   = 2'd2;
   localparam logic [1:0] ST_FROZEN = 2'd3;

   localparam int PC_MSB = 127;
   localparam int PC_LSB = 112;

`ifdef TRACE_TIMESTAMP_EN
   localparam int ENTRY_W = 48;
`else
   localparam int ENTRY_W = 32;
`endif

endpackage

// File: rtl/pc_trace_buffer_if.sv
// ---------------------------------------------------------------------------
// pc_trace_buffer_if
// Read-out (drain) channel of the trace buffer.
//   iRdReq   : host -> buffer, pop the head entry
//   oRdData  : buffer -> host, head entry (ENTRY_W bits, 0 when not valid)
//   oRdValid : buffer -> host, head entry is valid
// Modports: master = host/bench side, slave = trace buffer side.
// Build option: TRACE_TIMESTAMP_EN (through trace_pkg::ENTRY_W).
// ---------------------------------------------------------------------------
interface pc_trace_buffer_if;
   import trace_pkg::*;

   logic               iRdReq;
   logic [ENTRY_W-1:0] oRdData;
   logic               oRdValid;

   modport master (output iRdReq, input oRdData, input oRdValid);
   modport slave  (input iRdReq, output oRdData, output oRdValid);

endinterface

// File: rtl/pc_trace_buffer_ram.sv
// ---------------------------------------------------------------------------
// trace_ram
// DEPTH x ENTRY_W register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   Clock   : write clock
//   iWe     : write enable
//   iWAddr  : write address
//   iWData  : write data
//   iRAddr  : read address
//   oRData  : read data (combinational)
// Build option: TRACE_TIMESTAMP_EN (through trace_pkg::ENTRY_W).
// ---------------------------------------------------------------------------
module trace_ram
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic               Clock,
   input  logic               iWe,
   input  logic [AW-1:0]      iWAddr,
   input  logic [ENTRY_W-1:0] iWData,
   input  logic [AW-1:0]      iRAddr,
   output logic [ENTRY_W-1:0] oRData
);

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge Clock) begin
      if (iWe) begin
         mem_q[iWAddr] <= iWData;
      end
   end

   assign oRData = mem_q[iRAddr];

endmodule

// File: rtl/pc_trace_buffer.sv
// ---------------------------------------------------------------------------
// pc_trace_buffer
// Execution trace capture behind procMulticiclo. Every time PC (R7) changes
// while armed, one {PC, DIN} entry is written into a circular buffer. When
// PC hits the trigger address, iPostCount further entries are recorded and
// the buffer freezes; the host then drains the entries oldest-first.
// Ports:
//   Clock, Resetn : clock, synchronous active-low reset
//   iREGS         : {R7..R0} from procMulticiclo, PC = iREGS[127:112]
//   iDIN          : oDIN from procMulticiclo
//   iArm          : single-cycle arm/clear request (wins over capture/pop)
//   iTrigPC       : trigger address
//   iPostCount    : entries to record after the trigger entry
//   rd            : drain channel (iRdReq / oRdData / oRdValid)
//   oState        : FSM state (IDLE/ARMED/POST/FROZEN)
//   oCount        : entries held, 0..DEPTH
//   oWrapped      : an older entry was overwritten since arm
// Build option: TRACE_TIMESTAMP_EN appends a 16-bit cycle stamp to each
// entry; without it there is no counter and entries are 32 bits.
// ---------------------------------------------------------------------------
module pc_trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic [127:0]     iREGS,
   input  logic [15:0]      iDIN,
   input  logic             iArm,
   input  logic [15:0]      iTrigPC,
   input  logic [AW-1:0]    iPostCount,
   pc_trace_buffer_if.slave rd,
   output logic [1:0]       oState,
   output logic [AW:0]      oCount,
   output logic             oWrapped
);

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] AW_ONE   = AW'(1);

   logic [1:0]    state_q,   state_d;
   logic [15:0]   prev_pc_q, prev_pc_d;
   logic [AW-1:0] wptr_q,    wptr_d;
   logic [AW:0]   count_q,   count_d;
   logic          wrapped_q, wrapped_d;
   logic [AW-1:0] post_q,    post_d;

   logic [15:0]        pc;
   logic               capture;
   logic               wr_en;
   logic               rd_valid;
   logic               pop;
   logic [AW-1:0]      head;
   logic [ENTRY_W-1:0] wr_entry;
   logic [ENTRY_W-1:0] head_entry;
   logic               unused_regs;

   assign pc          = iREGS[PC_MSB:PC_LSB];
   assign unused_regs = ^iREGS[PC_LSB-1:0];

   assign capture  = (pc != prev_pc_q);
   // A simultaneous arm drops the capture and the pop.
   assign wr_en    = capture && !iArm && ((state_q == ST_ARMED) || (state_q == ST_POST));
   assign rd_valid = (state_q == ST_FROZEN) && (count_q != '0);
   assign pop      = rd.iRdReq && rd_valid && !iArm;
   // With count = DEPTH the low bits are 0, so the head lands on wptr itself.
   assign head     = wptr_q - count_q[AW-1:0];

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] stamp_q, stamp_d;

   // The stamp recorded is the counter value taken on the capture edge,
   // so an entry captured N cycles after arm carries N.
   assign stamp_d  = iArm ? 16'h0000 : (stamp_q + 16'h0001);
   assign wr_entry = {pc, iDIN, stamp_d};

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         stamp_q <= 16'h0000;
      end else begin
         stamp_q <= stamp_d;
      end
   end
`else
   assign wr_entry = {pc, iDIN};
`endif

   trace_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .Clock  (Clock),
      .iWe    (wr_en),
      .iWAddr (wptr_q),
      .iWData (wr_entry),
      .iRAddr (head),
      .oRData (head_entry)
   );

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      count_d   = count_q;
      wrapped_d = wrapped_q;
      post_d    = post_q;
      prev_pc_d = pc;

      if (iArm) begin
         state_d   = ST_ARMED;
         wptr_d    = '0;
         count_d   = '0;
         wrapped_d = 1'b0;
         post_d    = '0;
      end else begin
         if (wr_en) begin
            wptr_d = wptr_q + AW_ONE;
            if (count_q == CNT_FULL) begin
               wrapped_d = 1'b1;
            end else begin
               count_d = count_q + CNT_ONE;
            end

            if (state_q == ST_ARMED) begin
               if (pc == iTrigPC) begin
                  post_d  = iPostCount;
                  state_d = (iPostCount == '0) ? ST_FROZEN : ST_POST;
               end
            end else begin
               post_d = post_q - AW_ONE;
               if (post_q == AW_ONE) begin
                  state_d = ST_FROZEN;
               end
            end
         end

         if (pop) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q   <= ST_IDLE;
         prev_pc_q <= 16'h0000;
         wptr_q    <= '0;
         count_q   <= '0;
         wrapped_q <= 1'b0;
         post_q    <= '0;
      end else begin
         state_q   <= state_d;
         prev_pc_q <= prev_pc_d;
         wptr_q    <= wptr_d;
         count_q   <= count_d;
         wrapped_q <= wrapped_d;
         post_q    <= post_d;
      end
   end

   assign rd.oRdValid = rd_valid;
   assign rd.oRdData  = rd_valid ? head_entry : '0;
   assign oState      = state_q;
   assign oCount      = count_q;
   assign oWrapped    = wrapped_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_pc_trace_buffer
// Directed bench for pc_trace_buffer (DEPTH=16). Stimulus pushes the
// entries it expects to read back into a queue; a monitor pops and compares
// whenever an entry is popped from the DUT. State/count/flag checks are
// made inline.
// Build option: TRACE_TIMESTAMP_EN adds a stamp check.
// ---------------------------------------------------------------------------
module tb_pc_trace_buffer;
   import trace_pkg::*;

   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          Clock = 1'b0;
   logic          Resetn;
   logic [127:0]  iREGS;
   logic [15:0]   iDIN;
   logic          iArm;
   logic [15:0]   iTrigPC;
   logic [AW-1:0] iPostCount;
   logic [1:0]    oState;
   logic [AW:0]   oCount;
   logic          oWrapped;

   pc_trace_buffer_if rd ();

   pc_trace_buffer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .iREGS      (iREGS),
      .iDIN       (iDIN),
      .iArm       (iArm),
      .iTrigPC    (iTrigPC),
      .iPostCount (iPostCount),
      .rd         (rd.slave),
      .oState     (oState),
      .oCount     (oCount),
      .oWrapped   (oWrapped)
   );

   always #5 Clock = ~Clock;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic set_pc(input logic [15:0] pc);
      iREGS = {pc, 16'h0606, 16'h0505, 16'h0404, 16'h0303,
               16'h0202, 16'h0101, 16'h0000};
      iDIN  = 16'h1000 + pc;
      tick();
   endtask

   task automatic push_exp(input logic [15:0] pc);
      exp_q.push_back({pc, 16'h1000 + pc});
   endtask

   task automatic arm();
      iArm = 1'b1;
      tick();
      iArm = 1'b0;
   endtask

   task automatic drain(input string name);
      rd.iRdReq = 1'b1;
      for (int i = 0; i < 2 * DEPTH; i++) begin
         if (!rd.oRdValid) break;
         tick();
      end
      rd.iRdReq = 1'b0;
      check({name, "_valid_end"}, rd.oRdValid, 1'b0);
      check({name, "_queue_left"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Monitor: an entry is consumed on each edge where a pop is accepted.
   always @(negedge Clock) begin
      if (rd.oRdValid && rd.iRdReq) begin
         if (exp_q.size() == 0) begin
            check("drain_unexpected_entry", rd.oRdData[ENTRY_W-1 -: 32], 32'hFFFF_FFFF);
         end else begin
            check("drain_entry", rd.oRdData[ENTRY_W-1 -: 32], exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      Resetn     = 1'b0;
      iArm       = 1'b0;
      rd.iRdReq  = 1'b0;
      iREGS      = '0;
      iDIN       = '0;
      iTrigPC    = '0;
      iPostCount = '0;
      tick();
      tick();
      Resetn = 1'b1;

      // Reset state, then PC activity without arm.
      check("rst_state", oState, ST_IDLE);
      check("rst_count", oCount, 0);
      check("rst_wrapped", oWrapped, 0);
      check("rst_valid", rd.oRdValid, 0);
      check("rst_data", rd.oRdData, 0);
      set_pc(16'd0);
      set_pc(16'd1);
      set_pc(16'd2);
      check("idle_state", oState, ST_IDLE);
      check("idle_count", oCount, 0);
      check("idle_valid", rd.oRdValid, 0);

      // Trigger at 5, two post entries, PC 0..9.
      iTrigPC    = 16'd5;
      iPostCount = 4'd2;
      set_pc(16'd0);
      arm();
      check("arm_state", oState, ST_ARMED);
      check("arm_count", oCount, 0);
      for (int pc = 0; pc <= 9; pc++) begin
         set_pc(16'(pc));
         if (pc >= 1 && pc <= 7) push_exp(16'(pc));
         if (pc == 5) check("trig_state_post", oState, ST_POST);
         if (pc == 6) check("post_state_mid", oState, ST_POST);
         if (pc == 7) check("frozen_state", oState, ST_FROZEN);
      end
      check("frozen_count", oCount, 7);
      check("frozen_wrapped", oWrapped, 0);
      check("frozen_valid", rd.oRdValid, 1);
      drain("drain7");
      check("drained_count", oCount, 0);
      check("drained_state", oState, ST_FROZEN);

      // Wrap: trigger at 20, no post entries, PC 1..20.
      iTrigPC    = 16'd20;
      iPostCount = 4'd0;
      set_pc(16'd0);
      arm();
      for (int pc = 1; pc <= 20; pc++) begin
         set_pc(16'(pc));
         if (pc >= 5) push_exp(16'(pc));
      end
      check("wrap_state", oState, ST_FROZEN);
      check("wrap_count", oCount, 16);
      check("wrap_wrapped", oWrapped, 1);
      check("wrap_head", rd.oRdData[ENTRY_W-1 -: 32], {16'd5, 16'h1005});
      drain("drain_wrap");

      // Constant PC in ARMED writes nothing.
      iTrigPC = 16'd99;
      arm();
      check("rearm_wrapped", oWrapped, 0);
      set_pc(16'd21);
      set_pc(16'd22);
      check("hold_count_before", oCount, 2);
      for (int i = 0; i < 10; i++) tick();
      check("hold_count_after", oCount, 2);
      check("hold_state", oState, ST_ARMED);

      // Arm coinciding with a capture in POST.
      iTrigPC    = 16'd23;
      iPostCount = 4'd5;
      set_pc(16'd23);
      check("post2_state", oState, ST_POST);
      check("post2_count", oCount, 3);
      set_pc(16'd24);
      iArm = 1'b1;
      set_pc(16'd25);
      iArm = 1'b0;
      check("arm_in_post_count", oCount, 0);
      check("arm_in_post_state", oState, ST_ARMED);
      iTrigPC    = 16'd26;
      iPostCount = 4'd0;
      set_pc(16'd26);
      push_exp(16'd26);
      check("single_state", oState, ST_FROZEN);
      check("single_count", oCount, 1);
      drain("drain_single");

      // Reset in the middle of a drain.
      iTrigPC    = 16'd30;
      iPostCount = 4'd3;
      arm();
      for (int pc = 27; pc <= 33; pc++) begin
         set_pc(16'(pc));
         push_exp(16'(pc));
      end
      check("mid_state", oState, ST_FROZEN);
      check("mid_count", oCount, 7);
      rd.iRdReq = 1'b1;
      tick();
      tick();
      tick();
      rd.iRdReq = 1'b0;
      check("mid_count_after3", oCount, 4);
      check("mid_head", rd.oRdData[ENTRY_W-1 -: 32], {16'd30, 16'h1000 + 16'd30});
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      exp_q.delete();
      check("rst2_state", oState, ST_IDLE);
      check("rst2_count", oCount, 0);
      check("rst2_wrapped", oWrapped, 0);
      check("rst2_valid", rd.oRdValid, 0);
      check("rst2_data", rd.oRdData, 0);

`ifdef TRACE_TIMESTAMP_EN
      // Entry captured on the third edge after arm carries stamp 3.
      iTrigPC    = 16'd40;
      iPostCount = 4'd0;
      set_pc(16'd39);
      arm();
      tick();
      tick();
      set_pc(16'd40);
      check("stamp_state", oState, ST_FROZEN);
      check("stamp_entry", rd.oRdData, {16'd40, 16'h1028, 16'd3});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
